// File: rtl/avalon_mm_arbiter.sv
// N-to-1 Avalon-MM arbiter: round-robin command grant, lock across stalls, in-order read routing.
// Define AVALON_ARB_ERROR_EN to expose err_unexpected_rdv and err_pending_count.
module avalon_mm_arbiter #(
    parameter int NUM_HOSTS   = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_PENDING = 4,
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_HOSTS-1:0][ADDR_WIDTH-1:0]  host_address,
    input  logic [NUM_HOSTS-1:0][BE_WIDTH-1:0]    host_byteenable,
    input  logic [NUM_HOSTS-1:0]                  host_read,
    input  logic [NUM_HOSTS-1:0]                  host_write,
    input  logic [NUM_HOSTS-1:0][DATA_WIDTH-1:0]  host_host_to_agent,
    output logic [NUM_HOSTS-1:0]                  host_waitrequest,
    output logic [DATA_WIDTH-1:0]                 host_agent_to_host,
    output logic [NUM_HOSTS-1:0]                  host_readdatavalid,
    output logic [ADDR_WIDTH-1:0]                 mgr_address,
    output logic [BE_WIDTH-1:0]                   mgr_byteenable,
    output logic                                  mgr_read,
    output logic                                  mgr_write,
    output logic [DATA_WIDTH-1:0]                 mgr_host_to_agent,
    input  logic                                  mgr_waitrequest,
    input  logic [DATA_WIDTH-1:0]                 mgr_agent_to_host,
    input  logic                                  mgr_readdatavalid
`ifdef AVALON_ARB_ERROR_EN
    ,
    output logic                                  err_unexpected_rdv,
    output logic [$clog2(MAX_PENDING):0]          err_pending_count
`endif
);

    localparam int HW = $clog2(NUM_HOSTS);
    localparam int PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CW = $clog2(MAX_PENDING) + 1;

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } state_t;

    state_t          state, state_next;
    logic [HW-1:0]   rr_ptr;
    logic [HW-1:0]   locked_idx;
    logic [HW-1:0]   search_idx;
    logic [HW-1:0]   cand_idx;
    logic            search_found;
    logic [HW-1:0]   grant_idx;
    logic            grant_valid;
    logic            g_read;
    logic            g_write;
    logic [NUM_HOSTS-1:0] host_req;

    logic [HW-1:0]   fifo_mem [MAX_PENDING];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   pending_count;
    logic            fifo_full, fifo_empty;
    logic            accept, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_PENDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign host_req = host_read | host_write;

    // Round-robin search starts one past the last accepted host and wraps.
    always_comb begin
        search_idx   = '0;
        search_found = 1'b0;
        cand_idx     = '0;
        for (int k = 1; k <= NUM_HOSTS; k++) begin
            cand_idx = HW'((int'(rr_ptr) + k) % NUM_HOSTS);
            if (!search_found && host_req[cand_idx]) begin
                search_found = 1'b1;
                search_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        grant_idx   = (state == LOCKED) ? locked_idx : search_idx;
        grant_valid = (state == LOCKED) ? host_req[grant_idx] : search_found;
        g_write     = host_write[grant_idx];
        g_read      = host_read[grant_idx] & ~g_write;
    end

    assign fifo_full  = (pending_count == CW'(MAX_PENDING));
    assign fifo_empty = (pending_count == '0);

    // Reads are held off on a full FIFO even if a pop lands this cycle,
    // so readdatavalid never reaches waitrequest combinationally.
    assign mgr_read          = grant_valid & g_read & ~fifo_full;
    assign mgr_write         = grant_valid & g_write;
    assign mgr_address       = host_address[grant_idx];
    assign mgr_byteenable    = host_byteenable[grant_idx];
    assign mgr_host_to_agent = host_host_to_agent[grant_idx];

    assign accept = grant_valid & ~mgr_waitrequest & (g_write | ~fifo_full);
    assign push   = accept & g_read;
    assign pop    = mgr_readdatavalid & ~fifo_empty;

    assign host_agent_to_host = mgr_agent_to_host;

    always_comb begin
        host_waitrequest   = '1;
        host_readdatavalid = '0;
        for (int i = 0; i < NUM_HOSTS; i++) begin
            if (accept && grant_idx == HW'(i)) begin
                host_waitrequest[i] = 1'b0;
            end
            if (pop && fifo_mem[rd_ptr] == HW'(i)) begin
                host_readdatavalid[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = UNLOCKED;
        if (grant_valid && !accept) begin
            state_next = LOCKED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= UNLOCKED;
            rr_ptr     <= HW'(NUM_HOSTS - 1);
            locked_idx <= '0;
        end else begin
            state <= state_next;
            if (state_next == LOCKED) begin
                locked_idx <= grant_idx;
            end
            if (accept) begin
                rr_ptr <= grant_idx;
            end
        end
    end

    // Pending-read FIFO of host indices; storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            pending_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   pending_count <= pending_count + 1'b1;
                2'b01:   pending_count <= pending_count - 1'b1;
                default: pending_count <= pending_count;
            endcase
        end
    end

`ifdef AVALON_ARB_ERROR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_unexpected_rdv <= 1'b0;
        end else if (mgr_readdatavalid && fifo_empty) begin
            err_unexpected_rdv <= 1'b1;
        end
    end

    assign err_pending_count = pending_count;
`endif

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Directed self-checking bench for avalon_mm_arbiter (3 hosts, 4 pending reads).
module tb_avalon_mm_arbiter;

    logic clk = 1'b0;
    logic rst;

    logic [2:0][31:0] host_address;
    logic [2:0][3:0]  host_byteenable;
    logic [2:0]       host_read;
    logic [2:0]       host_write;
    logic [2:0][31:0] host_host_to_agent;
    logic [2:0]       host_waitrequest;
    logic [31:0]      host_agent_to_host;
    logic [2:0]       host_readdatavalid;
    logic [31:0]      mgr_address;
    logic [3:0]       mgr_byteenable;
    logic             mgr_read;
    logic             mgr_write;
    logic [31:0]      mgr_host_to_agent;
    logic             mgr_waitrequest;
    logic [31:0]      mgr_agent_to_host;
    logic             mgr_readdatavalid;
`ifdef AVALON_ARB_ERROR_EN
    logic             err_unexpected_rdv;
    logic [2:0]       err_pending_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [2:0]  exp3;
    int          seq_d [4];
    logic [31:0] dat_d [4];

    avalon_mm_arbiter #(
        .NUM_HOSTS  (3),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MAX_PENDING(4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .host_address      (host_address),
        .host_byteenable   (host_byteenable),
        .host_read         (host_read),
        .host_write        (host_write),
        .host_host_to_agent(host_host_to_agent),
        .host_waitrequest  (host_waitrequest),
        .host_agent_to_host(host_agent_to_host),
        .host_readdatavalid(host_readdatavalid),
        .mgr_address       (mgr_address),
        .mgr_byteenable    (mgr_byteenable),
        .mgr_read          (mgr_read),
        .mgr_write         (mgr_write),
        .mgr_host_to_agent (mgr_host_to_agent),
        .mgr_waitrequest   (mgr_waitrequest),
        .mgr_agent_to_host (mgr_agent_to_host),
        .mgr_readdatavalid (mgr_readdatavalid)
`ifdef AVALON_ARB_ERROR_EN
        ,
        .err_unexpected_rdv(err_unexpected_rdv),
        .err_pending_count (err_pending_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] addr_of(input int h);
        return 32'h1000 + 32'(h) * 32'h100;
    endfunction

    function automatic logic [31:0] wdata_of(input int h);
        return 32'hD000_0000 + 32'(h);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs settle before checks.
    task automatic applyStimulus(input logic [2:0] rd, input logic [2:0] wr, input logic wt,
                                 input logic rdv, input logic [31:0] rdata);
        host_read         = rd;
        host_write        = wr;
        mgr_waitrequest   = wt;
        mgr_readdatavalid = rdv;
        mgr_agent_to_host = rdata;
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            host_address[i]       = addr_of(i);
            host_host_to_agent[i] = wdata_of(i);
            host_byteenable[i]    = 4'(4'hF >> i);
        end
        seq_d = '{0, 1, 1, 0};
        dat_d = '{32'hA0, 32'hB1, 32'hB2, 32'hA3};
        rst = 1'b1;
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        checkOutput("rstRdv", 32'(host_readdatavalid), 32'h0);
        checkOutput("rstWait", 32'(host_waitrequest), 32'h7);
        checkOutput("rstMgrRead", 32'(mgr_read), 32'h0);
        checkOutput("rstMgrWrite", 32'(mgr_write), 32'h0);
`ifdef AVALON_ARB_ERROR_EN
        checkOutput("rstErr", 32'(err_unexpected_rdv), 32'h0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two hosts reading continuously, responses three cycles behind.
        for (int c = 0; c < 7; c++) begin
            applyStimulus((c < 4) ? 3'b011 : 3'b000, 3'b000, 1'b0, (c >= 3), 32'h100 + 32'(c));
            if (c < 4) begin
                exp3 = ~(3'b001 << (c % 2));
                checkOutput("rrRead", 32'(mgr_read), 32'h1);
                checkOutput("rrAddr", mgr_address, addr_of(c % 2));
                checkOutput("rrWait", 32'(host_waitrequest), 32'(exp3));
            end
            if (c >= 3) begin
                exp3 = 3'b001 << ((c - 3) % 2);
                checkOutput("rrRdv", 32'(host_readdatavalid), 32'(exp3));
                checkOutput("rrData", host_agent_to_host, 32'h100 + 32'(c));
            end
            next_cycle();
        end

        // Host 0 write moves the pointer so host 1 wins the next contest.
        applyStimulus(3'b000, 3'b001, 1'b0, 1'b0, 32'h0);
        checkOutput("preWrite", 32'(mgr_write), 32'h1);
        checkOutput("preWait", 32'(host_waitrequest), 32'h6);
        next_cycle();

        // Host 1 write stalled four cycles while host 0 keeps requesting.
        for (int w = 0; w < 5; w++) begin
            applyStimulus(3'b001, 3'b010, (w < 4), 1'b0, 32'h0);
            checkOutput("lockWrite", 32'(mgr_write), 32'h1);
            checkOutput("lockRead", 32'(mgr_read), 32'h0);
            checkOutput("lockAddr", mgr_address, addr_of(1));
            checkOutput("lockData", mgr_host_to_agent, wdata_of(1));
            checkOutput("lockWait", 32'(host_waitrequest), (w < 4) ? 32'h7 : 32'h5);
            next_cycle();
        end
        applyStimulus(3'b001, 3'b000, 1'b0, 1'b0, 32'h0);
        checkOutput("afterLockRead", 32'(mgr_read), 32'h1);
        checkOutput("afterLockAddr", mgr_address, addr_of(0));
        checkOutput("afterLockWait", 32'(host_waitrequest), 32'h6);
        next_cycle();
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'h55);
        checkOutput("afterLockRdv", 32'(host_readdatavalid), 32'h1);
        next_cycle();

        // Fill the FIFO from host 0; a host 1 write still gets through.
        for (int t = 0; t < 8; t++) begin
            applyStimulus(3'b001, (t == 4) ? 3'b010 : 3'b000, 1'b0, (t == 6), 32'h66);
            if (t < 4 || t == 7) begin
                checkOutput("fullRead", 32'(mgr_read), 32'h1);
                checkOutput("fullWait", 32'(host_waitrequest), 32'h6);
            end else if (t == 4) begin
                checkOutput("fullWrite", 32'(mgr_write), 32'h1);
                checkOutput("fullWriteAddr", mgr_address, addr_of(1));
                checkOutput("fullWriteWait", 32'(host_waitrequest), 32'h5);
            end else begin
                checkOutput("fullBlocked", 32'(mgr_read), 32'h0);
                checkOutput("fullBlockedWr", 32'(mgr_write), 32'h0);
                checkOutput("fullBlockedWait", 32'(host_waitrequest), 32'h7);
            end
            if (t == 6) begin
                checkOutput("fullPopRdv", 32'(host_readdatavalid), 32'h1);
            end
`ifdef AVALON_ARB_ERROR_EN
            if (t == 5) begin
                checkOutput("fullCount", 32'(err_pending_count), 32'h4);
            end
`endif
            next_cycle();
        end
        for (int d = 0; d < 4; d++) begin
            applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'h70 + 32'(d));
            checkOutput("drainRdv", 32'(host_readdatavalid), 32'h1);
            next_cycle();
        end

        // Interleaved reads 0,1,1,0 then a response burst.
        for (int i = 0; i < 4; i++) begin
            exp3 = 3'b001 << seq_d[i];
            applyStimulus(exp3, 3'b000, 1'b0, 1'b0, 32'h0);
            checkOutput("ilvRead", 32'(mgr_read), 32'h1);
            checkOutput("ilvAddr", mgr_address, addr_of(seq_d[i]));
            exp3 = ~exp3;
            checkOutput("ilvWait", 32'(host_waitrequest), 32'(exp3));
            next_cycle();
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, dat_d[i]);
            exp3 = 3'b001 << seq_d[i];
            checkOutput("ilvRdv", 32'(host_readdatavalid), 32'(exp3));
            checkOutput("ilvData", host_agent_to_host, dat_d[i]);
            next_cycle();
        end

        // Reset with two reads outstanding; late responses are dropped.
        applyStimulus(3'b001, 3'b000, 1'b0, 1'b0, 32'h0);
        next_cycle();
        applyStimulus(3'b010, 3'b000, 1'b0, 1'b0, 32'h0);
        next_cycle();
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
`ifdef AVALON_ARB_ERROR_EN
        checkOutput("preRstCount", 32'(err_pending_count), 32'h2);
`endif
        rst = 1'b1;
        #1;
        checkOutput("midRstWait", 32'(host_waitrequest), 32'h7);
        next_cycle();
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            applyStimulus(3'b000, 3'b000, 1'b0, 1'b1, 32'hEE);
            checkOutput("lateRdv", 32'(host_readdatavalid), 32'h0);
            next_cycle();
        end
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
`ifdef AVALON_ARB_ERROR_EN
        checkOutput("errSticky", 32'(err_unexpected_rdv), 32'h1);
        checkOutput("errCount", 32'(err_pending_count), 32'h0);
`endif

        // All three hosts writing; host 2 also asserts read.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(3'b100, 3'b111, 1'b0, 1'b0, 32'h0);
            exp3 = ~(3'b001 << (k % 3));
            checkOutput("rr3Addr", mgr_address, addr_of(k % 3));
            checkOutput("rr3Data", mgr_host_to_agent, wdata_of(k % 3));
            checkOutput("rr3Be", 32'(mgr_byteenable), 32'(4'hF >> (k % 3)));
            checkOutput("rr3Write", 32'(mgr_write), 32'h1);
            checkOutput("rr3Read", 32'(mgr_read), 32'h0);
            checkOutput("rr3Wait", 32'(host_waitrequest), 32'(exp3));
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
